instr_fetch_arbiter: RTL
========================

Name: instr_fetch_arbiter

Overview:
- Sits directly upstream of the per-warp fetchers; owns the single instruction-memory read port.
- Accepts fetch requests from NUM_REQUESTERS fetchers, grants them round-robin, and issues one memory read at a time.
- Returns each instruction on the granted fetcher's ready/data pair, using the same valid/ready contract the fetcher already drives.

Parameters:
- NUM_REQUESTERS, 4, number of fetchers served; must be ≥1. The pointer width is $clog2 of this value, minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQUESTERS  per-fetcher request; this is the fetcher's instruction_mem_read_valid
- req_address  in  NUM_REQUESTERS x IMEM_ADDR_BITS  per-fetcher address (packed array of instruction_memory_address_t)
- req_ready  out  NUM_REQUESTERS  per-fetcher completion, driven to the fetcher's instruction_mem_read_ready
- req_data  out  NUM_REQUESTERS x INSTR_BITS  per-fetcher instruction (packed array of instruction_t)
- mem_read_valid  out  1  request to instruction memory
- mem_read_address  out  IMEM_ADDR_BITS  memory address
- mem_read_ready  in  1  memory data valid this cycle
- mem_read_data  in  INSTR_BITS  memory instruction

Behaviour:
- All outputs are registered.
- Reset, asserted asynchronously at any time including mid-transaction:
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - mem_read_valid=0, mem_read_address=0.
  - req_ready=0, every req_data lane=0.
  - Any in-flight memory read is abandoned. The memory is required to tolerate valid dropping.
- FSM states: IDLE, READ_WAITING, RELAYING.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQUESTERS. Select the first index with req_valid set.
  - If a requester is found: grant_idx<=idx, mem_read_address<=req_address[idx], mem_read_valid<=1, go to READ_WAITING.
  - If none is found: stay in IDLE, outputs unchanged.
- READ_WAITING:
  - mem_read_valid and mem_read_address are held stable until mem_read_ready is sampled high.
  - On mem_read_ready:
    - mem_read_valid<=0.
    - req_data[grant_idx]<=mem_read_data; other lanes are unchanged.
    - If req_valid[grant_idx] is still 1: req_ready[grant_idx]<=1, go to RELAYING.
    - If the requester has abandoned the request: discard the data, rr_ptr<=grant_idx+1 (wrapping), go to IDLE.
- RELAYING:
  - req_ready[grant_idx] stays high and req_data stays stable while req_valid[grant_idx]=1.
  - When req_valid[grant_idx]=0: req_ready<=0, rr_ptr<=grant_idx+1 (wraps to 0 after NUM_REQUESTERS-1), go to IDLE.
- Only one bit of req_ready is ever high at a time.
- Non-granted requesters are ignored until the block returns to IDLE. Each lane's req_data holds its last delivered value.
- Latency:
  - Request sampled in IDLE at edge N gives mem_read_valid high after edge N.
  - With mem_read_ready high on the first READ_WAITING cycle, req_ready is high after edge N+1.
  - There is at least one IDLE cycle between consecutive grants.
- Simultaneous events:
  - A requester reasserting valid on the same edge it drops is treated as a new request. It is only eligible in IDLE, behind the rr order.
  - A full round-robin sweep guarantees no starvation. Worst-case wait is NUM_REQUESTERS-1 transactions.
- Address and data widths come from the shared types. No arithmetic is performed beyond the pointer increment modulo NUM_REQUESTERS, which uses an explicit compare rather than relying on power-of-2 wrap.

Optional Feature:
- Macro IFETCH_ARB_LAST_LINE_BYPASS_EN.
- When defined:
  - A single-entry buffer holds last_valid, last_address and last_instruction, loaded on every completed memory read.
  - In IDLE, if last_valid and the selected req_address equals last_address: skip memory, load req_data[idx]<=last_instruction, req_ready[idx]<=1, go directly to RELAYING. mem_read_valid stays 0.
  - last_valid is cleared on reset.
- When undefined: no buffer; every grant performs a memory read.

Decomposition:
- The following belong in the shared common package next to instruction_t and instruction_memory_address_t:
  - instr_fetch_arbiter_state_t enum {IDLE, READ_WAITING, RELAYING}.
  - IMEM_ADDR_BITS and INSTR_BITS constants.
- One natural sub-module is rr_priority_picker: combinational, taking req_valid and rr_ptr and producing found and idx. It is reusable by the data-memory arbiter.
- Add an instr_fetch_arbiter_wrapper with flattened ports for Verilator benches.

Test Plan:
- Single requester, lane 2, address 0x010, memory returns 0xDEADBEEF with ready 3 cycles after mem_read_valid -> mem_read_address=0x010 held for 3 cycles; req_ready[2]=1 with req_data[2]=0xDEADBEEF until req_valid[2] drops; then IDLE.
- All 4 lanes requesting continuously (lane i at address 0x100+i), rr_ptr=0, memory ready in 1 cycle -> grant order 0,1,2,3,0; mem_read_address sequence 0x100,0x101,0x102,0x103,0x100; never two req_ready bits high.
- Lane 1 drops req_valid during READ_WAITING -> data discarded, req_ready stays 0, next grant goes to lane 2 if it is valid.
- Reset asserted asynchronously mid READ_WAITING (address 0x044) -> mem_read_valid and req_ready are 0 immediately; after release, lane 0 is served first.
- With IFETCH_ARB_LAST_LINE_BYPASS_EN: lane 0 reads 0x020 (data 0x12345678), then lane 3 requests 0x020 -> no mem_read_valid pulse; req_ready[3]=1 with 0x12345678 one cycle after grant.
- Lane 3 only, rr_ptr=3 -> after completion rr_ptr wraps to 0; lane 3 is re-granted on its next request.

Source files
------------

// File: rtl/instr_fetch_arbiter_pkg.sv
// Shared fetch-path types: instruction/address widths and the arbiter state encoding.
package instr_fetch_arbiter_pkg;

    localparam int unsigned IMEM_ADDR_BITS = 12;
    localparam int unsigned INSTR_BITS     = 32;

    typedef logic [IMEM_ADDR_BITS-1:0] instruction_memory_address_t;
    typedef logic [INSTR_BITS-1:0]     instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAITING,
        RELAYING
    } instr_fetch_arbiter_state_t;

    // Pointer width for n requesters; a single requester still gets a 1-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 1) begin
            w = $unsigned($clog2(n));
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request at or after rr_ptr, wrapping.
// Purely combinational so it can be shared with the data-memory arbiter.
module rr_priority_picker
    import instr_fetch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned PTR_W          = ptr_width(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req_valid,
    input  logic [PTR_W-1:0]          rr_ptr,
    output logic                      found,
    output logic [PTR_W-1:0]          idx
);

    int unsigned cand;

    // Walk NUM_REQUESTERS candidates starting at rr_ptr; wrap by compare, not by truncation.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQUESTERS) begin
                cand = cand - NUM_REQUESTERS;
            end
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Instruction fetch arbiter: owns the single instruction-memory read port and serves
// NUM_REQUESTERS fetchers round-robin, one memory read at a time. All outputs registered.
// Optional build macro IFETCH_ARB_LAST_LINE_BYPASS_EN adds a one-entry last-read buffer
// that answers a repeated address without touching memory.
module instr_fetch_arbiter
    import instr_fetch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_REQUESTERS-1:0]                         req_valid,
    input  instruction_memory_address_t [NUM_REQUESTERS-1:0]  req_address,
    output logic [NUM_REQUESTERS-1:0]                         req_ready,
    output instruction_t [NUM_REQUESTERS-1:0]                 req_data,
    output logic                                              mem_read_valid,
    output instruction_memory_address_t                       mem_read_address,
    input  logic                                              mem_read_ready,
    input  instruction_t                                      mem_read_data
);

    localparam int unsigned      PTR_W    = ptr_width(NUM_REQUESTERS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQUESTERS - 1);

    instr_fetch_arbiter_state_t state;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           grant_idx;
    logic [PTR_W-1:0]           next_ptr;
    logic                       pick_found;
    logic [PTR_W-1:0]           pick_idx;

    rr_priority_picker #(
        .NUM_REQUESTERS(NUM_REQUESTERS),
        .PTR_W         (PTR_W)
    ) u_picker (
        .req_valid(req_valid),
        .rr_ptr   (rr_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Next round-robin start is one past the finished grant, explicit wrap for any count.
    assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

`ifdef IFETCH_ARB_LAST_LINE_BYPASS_EN
    logic                        last_valid;
    instruction_memory_address_t last_address;
    instruction_t                last_instruction;
    logic                        bypass_hit;

    assign bypass_hit = last_valid && (req_address[pick_idx] == last_address);

    // Capture every completed memory read, even one whose requester walked away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_valid       <= 1'b0;
            last_address     <= '0;
            last_instruction <= '0;
        end else if (state == READ_WAITING && mem_read_ready) begin
            last_valid       <= 1'b1;
            last_address     <= mem_read_address;
            last_instruction <= mem_read_data;
        end
    end
`endif

    // Arbitration FSM; drives every output directly from registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant_idx        <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            req_ready        <= '0;
            req_data         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
`ifdef IFETCH_ARB_LAST_LINE_BYPASS_EN
                        if (bypass_hit) begin
                            req_data[pick_idx]  <= last_instruction;
                            req_ready[pick_idx] <= 1'b1;
                            state               <= RELAYING;
                        end else
`endif
                        begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= req_address[pick_idx];
                            state            <= READ_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready) begin
                        mem_read_valid      <= 1'b0;
                        req_data[grant_idx] <= mem_read_data;
                        if (req_valid[grant_idx]) begin
                            req_ready[grant_idx] <= 1'b1;
                            state                <= RELAYING;
                        end else begin
                            // Requester gave up: no handshake, move on.
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end
                end
                RELAYING: begin
                    if (!req_valid[grant_idx]) begin
                        req_ready <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
